// File: rtl/crc_pkg.sv
// Shared CRC-9 definitions for the serial generator / checker pair.
package crc_pkg;
   localparam int              CRC9_W     = 9;
   localparam int              CRC_DATA_W = 10;
   localparam logic [CRC9_W-1:0] CRC9_POLY = 9'h083;  // x^9+x^7+x+1, x^9 implicit

   typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} crc_rx_state_t;

   // One step of the bit-serial division (init 0, no reflection, no final XOR).
   function automatic logic [CRC9_W-1:0] crc9_next(input logic [CRC9_W-1:0] rem,
                                                   input logic              b);
      logic fb;
      fb = b ^ rem[CRC9_W-1];
      return {rem[CRC9_W-2:0], 1'b0} ^ (fb ? CRC9_POLY : '0);
   endfunction
endpackage

// File: rtl/crc_lfsr_serial.sv
// Bit-serial polynomial divider. clr zeroes the remainder; when clr and en
// coincide the bit is divided into a freshly cleared remainder.
module crc_lfsr_serial
   import crc_pkg::*;
#(
   parameter int               CRC_W = CRC9_W,
   parameter logic [CRC_W-1:0] POLY  = CRC9_POLY
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             bit_in,
   output logic [CRC_W-1:0] rem
);
   logic [CRC_W-1:0] rem_q, rem_d, base;
   logic             fb;

   // Next remainder: optional clear, then optional division step.
   always_comb begin
      base  = clr ? '0 : rem_q;
      fb    = bit_in ^ base[CRC_W-1];
      rem_d = base;
      if (en) rem_d = {base[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
   end

   // Remainder register.
   always_ff @(posedge clk) begin
      if (reset) rem_q <= '0;
      else       rem_q <= rem_d;
   end

   assign rem = rem_q;
endmodule

// File: rtl/crc9_frame_checker.sv
// Receive-side CRC-9 frame checker: rebuilds the payload from a serial
// codeword (data MSB first, then CRC) and flags a zero remainder.
// Optional macro CRC_ERR_CNT_EN adds a saturating bad-frame counter.
module crc9_frame_checker
   import crc_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sof,
   input  logic                  bit_valid,
   input  logic                  bit_in,
   output logic                  busy,
   output logic                  frame_done,
   output logic [CRC_DATA_W-1:0] data_out,
   output logic                  crc_ok
`ifdef CRC_ERR_CNT_EN
   ,
   input  logic                  err_clr,
   output logic [7:0]            err_cnt
`endif
);
   localparam logic [3:0] DATA_LAST = 4'(CRC_DATA_W - 1);
   localparam logic [3:0] CRC_LAST  = 4'(CRC9_W - 1);

   crc_rx_state_t         state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [CRC_DATA_W-1:0] payload_q, payload_d;
   logic [CRC_DATA_W-1:0] data_q, data_d;
   logic                  ok_q, ok_d;
   logic                  lf_clr, lf_en;
   logic [CRC9_W-1:0]     rem;

   crc_lfsr_serial #(.CRC_W(CRC9_W), .POLY(CRC9_POLY)) u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .clr    (lf_clr),
      .en     (lf_en),
      .bit_in (bit_in),
      .rem    (rem)
   );

   // FSM next state, bit counting, payload shift and result capture.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      payload_d = payload_q;
      data_d    = data_q;
      ok_d      = ok_q;
      lf_clr    = 1'b0;
      lf_en     = 1'b0;
      if (sof && bit_valid) begin
         // New frame from any state; an in-flight frame is dropped silently.
         state_d   = DATA;
         cnt_d     = 4'd1;
         payload_d = {{(CRC_DATA_W-1){1'b0}}, bit_in};
         lf_clr    = 1'b1;
         lf_en     = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: ;
            DATA: if (bit_valid) begin
               lf_en     = 1'b1;
               payload_d = {payload_q[CRC_DATA_W-2:0], bit_in};
               if (cnt_q == DATA_LAST) begin
                  state_d = CRC;
                  cnt_d   = 4'd0;
               end else cnt_d = cnt_q + 4'd1;
            end
            CRC: if (bit_valid) begin
               lf_en = 1'b1;
               if (cnt_q == CRC_LAST) begin
                  // Capture results now so they are valid alongside frame_done.
                  state_d = DONE;
                  cnt_d   = 4'd0;
                  data_d  = payload_q;
                  ok_d    = (crc9_next(rem, bit_in) == '0);
               end else cnt_d = cnt_q + 4'd1;
            end
            DONE: begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         payload_q <= '0;
         data_q    <= '0;
         ok_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         payload_q <= payload_d;
         data_q    <= data_d;
         ok_q      <= ok_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign frame_done = (state_q == DONE);
   assign data_out   = data_q;
   assign crc_ok     = ok_q;

`ifdef CRC_ERR_CNT_EN
   logic [7:0] err_q;

   // Saturating count of frames completed with a bad CRC; clear has priority.
   always_ff @(posedge clk) begin
      if (reset)                                          err_q <= '0;
      else if (err_clr)                                   err_q <= '0;
      else if (frame_done && !ok_q && err_q != 8'hFF)     err_q <= err_q + 8'd1;
   end

   assign err_cnt = err_q;
`endif
endmodule

// File: tb/tb_crc9_frame_checker.sv
// Scoreboard bench for crc9_frame_checker: stimulus pushes expected
// results, a negedge monitor pops and compares on each frame_done.
module tb_crc9_frame_checker;
   logic       clk = 1'b0;
   logic       reset, sof, bit_valid, bit_in, err_clr;
   logic       busy, frame_done, crc_ok;
   logic [9:0] data_out;
`ifdef CRC_ERR_CNT_EN
   logic [7:0] err_cnt;
`endif

   typedef struct { logic [9:0] d; logic ok; } exp_t;
   exp_t q[$];
   int   checks = 0, errors = 0;
   int   cyc_n = 0, pulses = 0, last_pulse = 0, prev_pulse = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n++;

   crc9_frame_checker dut (
      .clk(clk), .reset(reset), .sof(sof), .bit_valid(bit_valid), .bit_in(bit_in),
      .busy(busy), .frame_done(frame_done), .data_out(data_out), .crc_ok(crc_ok)
`ifdef CRC_ERR_CNT_EN
      , .err_clr(err_clr), .err_cnt(err_cnt)
`endif
   );

   // Monitor: every frame_done pulse must match the oldest expected frame.
   always @(negedge clk) begin
      if (frame_done) begin
         exp_t e;
         pulses++;
         prev_pulse = last_pulse;
         last_pulse = cyc_n;
         if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame_done cycle=%0d data_out=%h", cyc_n, data_out);
         end else begin
            e = q.pop_front();
            checks += 2;
            if (data_out !== e.d) begin
               errors++;
               $display("FAIL data_out got=%h exp=%h", data_out, e.d);
            end
            if (crc_ok !== e.ok) begin
               errors++;
               $display("FAIL crc_ok got=%b exp=%b data=%h", crc_ok, e.ok, e.d);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic cyc(input logic s, input logic v, input logic b);
      sof = s; bit_valid = v; bit_in = b;
      @(posedge clk); #1;
   endtask

   task automatic send_frame(input logic [9:0] d, input logic [8:0] c, input int gaps,
                             input logic exp_ok, input bit push);
      exp_t e;
      if (push) begin e.d = d; e.ok = exp_ok; q.push_back(e); end
      for (int i = 0; i < 19; i++) begin
         cyc(i == 0, 1'b1, (i < 10) ? d[9-i] : c[18-i]);
         for (int g = 0; g < gaps; g++) cyc(1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout cycle=%0d", cyc_n);
      $fatal(1, "timeout");
   end

   initial begin
      int p0;
      reset = 1'b1; sof = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; err_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("reset_busy", busy, 0);
      chk("reset_frame_done", frame_done, 0);
      chk("reset_data_out", data_out, 0);
      chk("reset_crc_ok", crc_ok, 0);
      // sof without bit_valid and bit_valid without sof are both ignored.
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b1);
      chk("idle_ignore_busy", busy, 0);

      // 1: data 0x001 + CRC 0x083, frame_done right after the last bit.
      send_frame(10'h001, 9'h083, 0, 1'b1, 1);
      chk("s1_latency_frame_done", frame_done, 1);
      cyc(0, 0, 0);
      chk("s1_done_one_cycle", frame_done, 0);

      // 2: data 0x200 + CRC 0x17B good; then bit 0 of the CRC flipped.
      send_frame(10'h200, 9'h17B, 0, 1'b1, 1);
      cyc(0, 0, 0);
      send_frame(10'h200, 9'h17A, 0, 1'b0, 1);
      cyc(0, 0, 0);
`ifdef CRC_ERR_CNT_EN
      chk("s2_err_cnt", err_cnt, 8'd1);
`endif

      // 3: all-zero frame with bit_valid toggling: exactly one pulse.
      p0 = pulses;
      send_frame(10'h000, 9'h000, 1, 1'b1, 1);
      repeat (3) cyc(0, 0, 0);
      chk("s3_one_pulse", pulses - p0, 1);

      // 4: 7 data bits then a restarting sof: only the second frame completes.
      p0 = pulses;
      for (int i = 0; i < 7; i++) cyc(i == 0, 1'b1, 1'b1);
      send_frame(10'h001, 9'h083, 0, 1'b1, 1);
      repeat (2) cyc(0, 0, 0);
      chk("s4_one_pulse", pulses - p0, 1);

      // 5: reset during bit 12 of a frame, then a clean frame.
      p0 = pulses;
      for (int i = 0; i < 12; i++) cyc(i == 0, 1'b1, 1'b1);
      reset = 1'b1;
      cyc(0, 0, 0);
      reset = 1'b0;
      chk("s5_busy", busy, 0);
      chk("s5_frame_done", frame_done, 0);
      chk("s5_data_out", data_out, 0);
      chk("s5_crc_ok", crc_ok, 0);
      repeat (25) cyc(0, 1, 1);
      chk("s5_no_pulse", pulses - p0, 0);
      send_frame(10'h200, 9'h17B, 0, 1'b1, 1);
      cyc(0, 0, 0);

      // 6: back-to-back frames, second sof lands in the DONE cycle.
      p0 = pulses;
      send_frame(10'h001, 9'h083, 0, 1'b1, 1);
      send_frame(10'h001, 9'h083, 0, 1'b1, 1);
      repeat (2) cyc(0, 0, 0);
      chk("s6_two_pulses", pulses - p0, 2);
      chk("s6_spacing", last_pulse - prev_pulse, 19);

`ifdef CRC_ERR_CNT_EN
      for (int n = 0; n < 256; n++) send_frame(10'h200, 9'h17A, 0, 1'b0, 1);
      repeat (2) cyc(0, 0, 0);
      chk("err_cnt_saturate", err_cnt, 8'hFF);
      err_clr = 1'b1;
      cyc(0, 0, 0);
      err_clr = 1'b0;
      chk("err_cnt_clear", err_cnt, 8'h00);
`endif

      repeat (3) cyc(0, 0, 0);
      chk("scoreboard_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
